// File: rtl/wb_sram_banks.sv
// wb_sram_banks: Wishbone slave onto NUM_BANKS single-port SRAMs; define WB_SRAM_BANKS_ERR_EN to add wbs_err_o
module wb_sram_banks #(
  parameter int          NUM_BANKS = 2,
  parameter int          ADDR_W    = 9,
  parameter int          DATA_W    = 32,
  parameter logic [31:0] BASE_ADDR = 32'h3000_0000,
  parameter int          READ_LAT  = 1
) (
  input  logic                        clk_i,
  input  logic                        rst_i,
  input  logic                        wbs_cyc_i,
  input  logic                        wbs_stb_i,
  input  logic                        wbs_we_i,
  input  logic [3:0]                  wbs_sel_i,
  input  logic [31:0]                 wbs_adr_i,
  input  logic [DATA_W-1:0]           wbs_dat_i,
  output logic                        wbs_ack_o,
`ifdef WB_SRAM_BANKS_ERR_EN
  output logic                        wbs_err_o,
`endif
  output logic [DATA_W-1:0]           wbs_dat_o,
  output logic [NUM_BANKS-1:0]        o_csb,
  output logic                        o_web,
  output logic [3:0]                  o_wmask,
  output logic [ADDR_W-1:0]           o_addr,
  output logic [DATA_W-1:0]           o_din,
  input  logic [NUM_BANKS*DATA_W-1:0] i_dout
);
  localparam int BW = $clog2(NUM_BANKS);
  localparam int BI = BW > 0 ? BW : 1;
  localparam int HI = ADDR_W + 2 + BW;
  typedef enum logic [1:0] {IDLE, ACCESS, WAIT, ACK} state_t;
  state_t state_q, state_d;
  logic [NUM_BANKS-1:0] csb_q, csb_d;
  logic web_q, web_d, ack_q, ack_d;
  logic [3:0] wmask_q, wmask_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] din_q, din_d, dat_q, dat_d;
  logic [BI-1:0] bank_q, bank_d, bank;
  logic [1:0] cnt_q, cnt_d;
  logic hit, bad;
  assign bank = BI'((wbs_adr_i >> (ADDR_W + 2)) & 32'(NUM_BANKS - 1));
  assign hit  = (wbs_adr_i >> HI) == (BASE_ADDR >> HI);
`ifdef WB_SRAM_BANKS_ERR_EN
  logic err_q, err_d;
  assign bad       = !hit || (!wbs_we_i && wbs_sel_i == 4'h0);
  assign wbs_err_o = err_q;
`else
  assign bad = !hit;
`endif
  // Next state: strobe one SRAM cycle, then either ack a write or count down the read latency
  always_comb begin
    state_d = state_q;
    csb_d   = '1;
    web_d   = 1'b1;
    wmask_d = wmask_q;
    addr_d  = addr_q;
    din_d   = din_q;
    dat_d   = dat_q;
    bank_d  = bank_q;
    cnt_d   = cnt_q;
    ack_d   = 1'b0;
`ifdef WB_SRAM_BANKS_ERR_EN
    err_d   = 1'b0;
`endif
    case (state_q)
      IDLE: if (wbs_cyc_i && wbs_stb_i && !ack_q) begin
        state_d = bad ? ACK : ACCESS;
        if (bad) begin
          dat_d = '0;
`ifdef WB_SRAM_BANKS_ERR_EN
          err_d = 1'b1;
`else
          ack_d = 1'b1;
`endif
        end else begin
          addr_d      = wbs_adr_i[ADDR_W+1:2];
          din_d       = wbs_dat_i;
          wmask_d     = wbs_we_i ? wbs_sel_i : 4'h0;
          web_d       = !wbs_we_i;
          csb_d[bank] = 1'b0;
          bank_d      = bank;
        end
      end
      ACCESS: begin
        state_d = !wbs_cyc_i ? IDLE : !web_q ? ACK : WAIT;
        ack_d   = wbs_cyc_i && !web_q;
        cnt_d   = 2'(READ_LAT - 1);
      end
      WAIT: begin
        state_d = !wbs_cyc_i ? IDLE : cnt_q == 2'd0 ? ACK : WAIT;
        ack_d   = wbs_cyc_i && cnt_q == 2'd0;
        dat_d   = ack_d ? i_dout[bank_q*DATA_W +: DATA_W] : dat_q;
        cnt_d   = cnt_q - 2'd1;
      end
      ACK: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end
  // State and registered outputs, cleared asynchronously
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      csb_q   <= '1;
      web_q   <= 1'b1;
      wmask_q <= '0;
      addr_q  <= '0;
      din_q   <= '0;
      dat_q   <= '0;
      bank_q  <= '0;
      cnt_q   <= '0;
      ack_q   <= 1'b0;
`ifdef WB_SRAM_BANKS_ERR_EN
      err_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      csb_q   <= csb_d;
      web_q   <= web_d;
      wmask_q <= wmask_d;
      addr_q  <= addr_d;
      din_q   <= din_d;
      dat_q   <= dat_d;
      bank_q  <= bank_d;
      cnt_q   <= cnt_d;
      ack_q   <= ack_d;
`ifdef WB_SRAM_BANKS_ERR_EN
      err_q   <= err_d;
`endif
    end
  end
  assign o_csb     = csb_q;
  assign o_web     = web_q;
  assign o_wmask   = wmask_q;
  assign o_addr    = addr_q;
  assign o_din     = din_q;
  assign wbs_ack_o = ack_q;
  assign wbs_dat_o = dat_q;
endmodule

// File: tb/tb_wb_sram_banks.sv
// tb_wb_sram_banks: two bridges (READ_LAT 1 and 3) checked against a flat-memory reference via scoreboard queues
module tb_wb_sram_banks;
  localparam logic [31:0] BASE = 32'h3000_0000;
  typedef struct { int d; logic [1:0] csb; logic web; logic [3:0] wm; logic [8:0] a; logic [31:0] din; int t; } st_t;
  typedef struct { int d; logic [31:0] dat; logic err; int t; } rs_t;
  logic clk = 1'b0, rst = 1'b1;
  logic cyc[2], stb[2], we[2], ack[2], err[2], web[2];
  logic [3:0] sel[2], wmask[2];
  logic [31:0] adr[2], dati[2], dato[2], din[2];
  logic [1:0] csb[2];
  logic [8:0] addr[2];
  logic [63:0] dout[2], p0[2], p1[2], p2[2];
  logic [31:0] mem[2][1024];
  bit wr[2][1024];
  logic [31:0] mdl[2][1024];
  logic [31:0] last_rd[2];
  int acks[2];
  int cyc_n = 0, checks = 0, errors = 0;
  st_t sq[$];
  rs_t rq[$];
  st_t s;
  rs_t r;

  always #5 clk = ~clk;

  wb_sram_banks #(.READ_LAT(1)) u0 (
    .clk_i(clk), .rst_i(rst), .wbs_cyc_i(cyc[0]), .wbs_stb_i(stb[0]), .wbs_we_i(we[0]),
    .wbs_sel_i(sel[0]), .wbs_adr_i(adr[0]), .wbs_dat_i(dati[0]), .wbs_ack_o(ack[0]),
`ifdef WB_SRAM_BANKS_ERR_EN
    .wbs_err_o(err[0]),
`endif
    .wbs_dat_o(dato[0]), .o_csb(csb[0]), .o_web(web[0]), .o_wmask(wmask[0]),
    .o_addr(addr[0]), .o_din(din[0]), .i_dout(dout[0]));

  wb_sram_banks #(.READ_LAT(3)) u1 (
    .clk_i(clk), .rst_i(rst), .wbs_cyc_i(cyc[1]), .wbs_stb_i(stb[1]), .wbs_we_i(we[1]),
    .wbs_sel_i(sel[1]), .wbs_adr_i(adr[1]), .wbs_dat_i(dati[1]), .wbs_ack_o(ack[1]),
`ifdef WB_SRAM_BANKS_ERR_EN
    .wbs_err_o(err[1]),
`endif
    .wbs_dat_o(dato[1]), .o_csb(csb[1]), .o_web(web[1]), .o_wmask(wmask[1]),
    .o_addr(addr[1]), .o_din(din[1]), .i_dout(dout[1]));

`ifndef WB_SRAM_BANKS_ERR_EN
  assign err[0] = 1'b0;
  assign err[1] = 1'b0;
`endif
  assign dout[0] = p0[0];
  assign dout[1] = p2[1];

  function automatic logic [31:0] init_val(input int i);
    return 32'(i) * 32'h9E37_79B9 + 32'h0BAD_F00D;
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] cur, input logic [31:0] v, input logic [3:0] m);
    logic [31:0] bm;
    bm = {{8{m[3]}}, {8{m[2]}}, {8{m[1]}}, {8{m[0]}}};
    return (cur & ~bm) | (v & bm);
  endfunction

  function automatic logic [31:0] sram_rd(input int d, input int j);
    return wr[d][j] ? mem[d][j] : init_val(j);
  endfunction

  function automatic int lat(input int d);
    return d == 0 ? 1 : 3;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc_n);
    end
  endtask

  // Cycle counter: value seen at a negedge is the index of the current cycle
  always @(posedge clk) cyc_n <= cyc_n + 1;

  // Behavioural SRAM macros: capture on the edge with csb low, read data delayed to suit each bridge
  always @(posedge clk) begin
    for (int d = 0; d < 2; d++)
      for (int b = 0; b < 2; b++)
        if (!csb[d][b]) begin
          if (!web[d]) begin
            mem[d][b*512 + int'(addr[d])] <= merge(sram_rd(d, b*512 + int'(addr[d])), din[d], wmask[d]);
            wr[d][b*512 + int'(addr[d])] <= 1'b1;
          end else
            p0[d][32*b +: 32] <= sram_rd(d, b*512 + int'(addr[d]));
        end
    p1 <= p0;
    p2 <= p1;
  end

  // Monitor: pop expected SRAM strobes and bus responses whenever the DUT presents them
  always @(negedge clk) begin
    for (int d = 0; d < 2; d++) begin
      if (csb[d] != 2'b11) begin
        if (sq.size() == 0) begin
          checks++; errors++;
          $display("FAIL strobe_unexpected dut%0d: csb=%b expected no strobe", d, csb[d]);
        end else begin
          s = sq.pop_front();
          chk("strobe_dut", 64'(d), 64'(s.d));
          chk("csb", 64'(csb[d]), 64'(s.csb));
          chk("web", 64'(web[d]), 64'(s.web));
          chk("wmask", 64'(wmask[d]), 64'(s.wm));
          chk("addr", 64'(addr[d]), 64'(s.a));
          chk("din", 64'(din[d]), 64'(s.din));
          chk("strobe_cycle", 64'(cyc_n), 64'(s.t));
        end
      end
      if (ack[d] || err[d]) begin
        acks[d]++;
        if (rq.size() == 0) begin
          checks++; errors++;
          $display("FAIL ack_unexpected dut%0d: ack=%b err=%b expected none", d, ack[d], err[d]);
        end else begin
          r = rq.pop_front();
          chk("resp_dut", 64'(d), 64'(r.d));
          chk("ack", 64'(ack[d]), 64'(!r.err));
`ifdef WB_SRAM_BANKS_ERR_EN
          chk("err", 64'(err[d]), 64'(r.err));
`endif
          chk("rdata", 64'(dato[d]), 64'(r.dat));
          chk("ack_cycle", 64'(cyc_n), 64'(r.t));
        end
      end
    end
  end

  task automatic issue(input int d, input bit w, input logic [31:0] a, input logic [3:0] s_, input logic [31:0] v,
                       output int k, output bit bad, output int idx);
    st_t st;
    @(negedge clk);
    k   = cyc_n;
    idx = int'((a >> 2) & 32'h3FF);
    bad = (a >> 12) != (BASE >> 12);
`ifdef WB_SRAM_BANKS_ERR_EN
    bad = bad || (!w && s_ == 4'h0);
`endif
    cyc[d] = 1'b1; stb[d] = 1'b1; we[d] = w; sel[d] = s_; adr[d] = a; dati[d] = v;
    if (!bad) begin
      st.d = d; st.csb = 2'b11; st.csb[idx >> 9] = 1'b0; st.web = !w;
      st.wm = w ? s_ : 4'h0; st.a = 9'(idx); st.din = v; st.t = k + 1;
      sq.push_back(st);
    end
  endtask

  task automatic txn(input int d, input bit w, input logic [31:0] a, input logic [3:0] s_, input logic [31:0] v);
    rs_t rs;
    int k, idx, n;
    bit bad;
    issue(d, w, a, s_, v, k, bad, idx);
    rs.d = d; rs.err = 1'b0;
    if (bad) begin
      rs.dat = '0; rs.t = k + 1; last_rd[d] = '0;
`ifdef WB_SRAM_BANKS_ERR_EN
      rs.err = 1'b1;
`endif
    end else if (w) begin
      mdl[d][idx] = merge(mdl[d][idx], v, s_);
      rs.dat = last_rd[d]; rs.t = k + 2;
    end else begin
      rs.dat = mdl[d][idx]; last_rd[d] = rs.dat; rs.t = k + 2 + lat(d);
    end
    rq.push_back(rs);
    n = 0;
    do begin
      @(negedge clk);
      n++;
      adr[d] = $urandom;
    end while (!(ack[d] || err[d]) && n < 30);
    if (!(ack[d] || err[d])) begin
      checks++; errors++;
      $display("FAIL ack_timeout dut%0d: no response after %0d cycles, required one", d, n);
      rq.delete();
    end
    cyc[d] = 1'b0; stb[d] = 1'b0;
  endtask

  task automatic abort_read(input int d, input logic [31:0] a);
    int k, idx, n0;
    bit bad;
    issue(d, 1'b0, a, 4'hF, 32'h0, k, bad, idx);
    repeat (2) @(negedge clk);
    cyc[d] = 1'b0; stb[d] = 1'b0;
    n0 = acks[d];
    repeat (8) @(negedge clk);
    chk("abort_no_ack", 64'(acks[d]), 64'(n0));
    chk("abort_dat_hold", 64'(dato[d]), 64'(last_rd[d]));
  endtask

  task automatic reset_mid(input int d, input logic [31:0] a);
    int k, idx;
    bit bad;
    issue(d, 1'b0, a, 4'hF, 32'h0, k, bad, idx);
    @(negedge clk);
    #2 rst = 1'b1;
    cyc[d] = 1'b0; stb[d] = 1'b0;
    #1;
    chk("rst_csb", 64'(csb[d]), 64'(2'b11));
    chk("rst_ack", 64'(ack[d]), 64'(1'b0));
    chk("rst_dat", 64'(dato[d]), 64'(0));
    chk("rst_web", 64'(web[d]), 64'(1'b1));
    chk("rst_addr", 64'(addr[d]), 64'(0));
    last_rd[0] = '0; last_rd[1] = '0;
    @(negedge clk);
    rst = 1'b0;
    repeat (6) @(negedge clk);
  endtask

  initial begin
    logic [31:0] a;
    int rnd;
    for (int d = 0; d < 2; d++) begin
      cyc[d] = 1'b0; stb[d] = 1'b0; we[d] = 1'b0; sel[d] = 4'h0; adr[d] = '0; dati[d] = '0;
      last_rd[d] = '0; acks[d] = 0;
      for (int i = 0; i < 1024; i++) mdl[d][i] = init_val(i);
    end
    repeat (2) @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      chk("reset_csb", 64'(csb[d]), 64'(2'b11));
      chk("reset_web", 64'(web[d]), 64'(1'b1));
      chk("reset_wmask", 64'(wmask[d]), 64'(0));
      chk("reset_addr", 64'(addr[d]), 64'(0));
      chk("reset_din", 64'(din[d]), 64'(0));
      chk("reset_ack", 64'(ack[d]), 64'(0));
      chk("reset_dat", 64'(dato[d]), 64'(0));
`ifdef WB_SRAM_BANKS_ERR_EN
      chk("reset_err", 64'(err[d]), 64'(0));
`endif
    end
    rst = 1'b0;
    for (int d = 0; d < 2; d++) begin
      txn(d, 1'b1, BASE, 4'hF, 32'hA5A5_1234);
      txn(d, 1'b0, BASE, 4'hF, 32'h0);
      txn(d, 1'b1, BASE + 32'h800, 4'hF, 32'hCAFE_0001);
      txn(d, 1'b0, BASE, 4'hF, 32'h0);
      txn(d, 1'b0, BASE + 32'h800, 4'hF, 32'h0);
      txn(d, 1'b1, BASE + 32'h4, 4'hF, 32'h1122_3344);
      txn(d, 1'b1, BASE + 32'h4, 4'b0010, 32'h0000_7700);
      txn(d, 1'b0, BASE + 32'h4, 4'hF, 32'h0);
      txn(d, 1'b0, 32'h3000_1000, 4'hF, 32'h0);
      txn(d, 1'b0, BASE + 32'h8, 4'hF, 32'h0);
      txn(d, 1'b1, BASE + 32'hC, 4'h0, 32'hFFFF_FFFF);
      txn(d, 1'b0, BASE + 32'hC, 4'hF, 32'h0);
      txn(d, 1'b0, BASE + 32'hC, 4'h0, 32'h0);
      txn(d, 1'b1, 32'h2FFF_FFFC, 4'hF, 32'h1);
    end
    abort_read(1, BASE + 32'h8);
    txn(1, 1'b0, BASE + 32'h8, 4'hF, 32'h0);
    reset_mid(1, BASE + 32'h804);
    txn(1, 1'b0, BASE + 32'h804, 4'hF, 32'h0);
    for (int d = 0; d < 2; d++)
      for (int i = 0; i < 60; i++) begin
        rnd = int'($urandom_range(0, 9));
        a = BASE + ($urandom_range(0, 1023) << 2) + $urandom_range(0, 3);
        if (rnd == 0) a = a + 32'h1000;
        else if (rnd == 1) a = a ^ 32'h8000_0000;
        txn(d, $urandom_range(0, 1) == 1, a, 4'($urandom_range(0, 15)), $urandom);
      end
    repeat (4) @(negedge clk);
    checks++;
    if (sq.size() != 0 || rq.size() != 0) begin
      errors++;
      $display("FAIL leftover_expectations: strobes=%0d responses=%0d required 0", sq.size(), rq.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/wb_sram_banks.md
Name: wb_sram_banks

Overview:
- Wishbone slave bridge that maps a contiguous address window onto NUM_BANKS single-port SRAM macros: word-addressed, 4-byte write mask, shared address/data buses, per-bank chip select.
- Successor to the fixed two-SRAM hookup in the user area. Bank count, depth, base address and read latency are parameters.
- Adds proper decode, wait-state handling, abort handling and out-of-range response.
- Sits between the management Wishbone port and the SRAM macros inside the user project.

Parameters:
- NUM_BANKS, 2, number of SRAM macros; power of two, 1..8
- ADDR_W, 9, word-address width of one macro (512 words)
- DATA_W, 32, data width; fixed to 32 (4 byte lanes)
- BASE_ADDR, 32'h3000_0000, byte base of window; aligned to window size NUM_BANKS*2^ADDR_W*4
- READ_LAT, 1, clock edges from SRAM capture edge to dout valid; 1..3

Ports:
- clk_i  in  1  clock; bus and SRAMs share it
- rst_i  in  1  asynchronous, active-high reset
- wbs_cyc_i  in  1  Wishbone cycle
- wbs_stb_i  in  1  Wishbone strobe
- wbs_we_i  in  1  write enable
- wbs_sel_i  in  4  byte selects
- wbs_adr_i  in  32  byte address
- wbs_dat_i  in  32  write data
- wbs_ack_o  out  1  acknowledge
- wbs_dat_o  out  32  read data
- o_csb  out  NUM_BANKS  per-bank chip select, active low
- o_web  out  1  write enable, active low, shared
- o_wmask  out  4  byte write mask, shared
- o_addr  out  ADDR_W  word address, shared
- o_din  out  32  write data, shared
- i_dout  in  NUM_BANKS*32  read data; bank k on bits [32k+31:32k]

Behaviour:
- Reset values: o_csb all 1, o_web=1, o_wmask=0, o_addr=0, o_din=0, wbs_ack_o=0, wbs_dat_o=0, FSM=IDLE.
- All outputs are registered.
- Decode, with BW = clog2(NUM_BANKS):
  - word = adr[ADDR_W+1:2]
  - bank = adr[ADDR_W+1+BW:ADDR_W+2]
  - hit when adr[31:ADDR_W+2+BW] equals the same bits of BASE_ADDR
  - adr[1:0] ignored
- States: IDLE, ACCESS, WAIT, ACK.
- IDLE, on cyc&stb&!ack sampled at edge E0 (request present in cycle 0):
  - hit: load o_addr/o_din/o_wmask (wmask = sel if we, else 0), o_web = !we, o_csb[bank]=0 -> ACCESS
  - miss: wbs_dat_o=0, ack=1 -> ACK. No SRAM access.
- ACCESS, one cycle: SRAM samples at the next edge E1; o_csb returns to all 1, o_web to 1.
  - write: ack=1 -> ACK. Write ack high in cycle 2.
  - read: -> WAIT with latency counter = READ_LAT-1.
- WAIT: count down. At count 0, capture the selected bank's i_dout into wbs_dat_o, ack=1 -> ACK.
  - Read ack high in cycle 2+READ_LAT.
  - Bank index is latched at request; changing adr during WAIT has no effect.
- ACK: ack held exactly one cycle -> IDLE. A back-to-back request is accepted in the cycle after ack drops. No pipelined requests.
- Abort: cyc low in ACCESS or WAIT -> IDLE next edge, no ack, wbs_dat_o unchanged. A write already strobed to the SRAM completes; that is acceptable.
- sel=0 write: SRAM cycle still issued with wmask=0 and acked normally; memory unchanged.
- wbs_dat_o holds its last value between reads; unchanged on writes.
- Async reset mid-transaction: all outputs return to reset values immediately; no ack is emitted afterwards.

Optional Feature:
- Macro WB_SRAM_BANKS_ERR_EN.
- Defined:
  - adds output port wbs_err_o (1 bit, reset 0)
  - an out-of-range access asserts wbs_err_o, not ack, for one cycle in ACK state; wbs_dat_o=0
  - a read whose wbs_sel_i==0 is also errored
- Undefined: no wbs_err_o port. Misses are acked with data 0, as in Behaviour.

Test Plan:
- Write 32'hA5A5_1234, sel=4'hF, to BASE+0x000, then read it back -> bank0 csb low one cycle; write ack cycle 2, read ack cycle 3 (READ_LAT=1); wbs_dat_o=32'hA5A5_1234.
- Write 32'hCAFE_0001 to BASE+0x800 (bank1, word 0) -> o_csb=2'b01, o_addr=0; read of BASE+0x000 does not return 32'hCAFE_0001 (bank isolation).
- Byte write sel=4'b0010, data 32'h0000_7700, at BASE+0x004 over prior 32'h1122_3344 -> o_wmask=4'b0010; readback 32'h1122_7744.
- Read 32'h3000_1000 (first address past a 4 KB window) -> no csb activity; ack in cycle 1 with data 0 (with WB_SRAM_BANKS_ERR_EN: wbs_err_o=1, ack stays 0).
- READ_LAT=3 build: read BASE+0x008 -> ack in cycle 5, data equals the model's value at word 2.
- Drop cyc in WAIT (READ_LAT=3) -> no ack, FSM IDLE next edge. Assert rst_i during ACCESS -> o_csb=all 1 and ack=0 immediately. The next read succeeds.
